ctrl_pipe_stager: RTL and testbench
===================================

Name: ctrl_pipe_stager

Overview:
- Sits behind the main control decoder. Takes its decoded ID-stage control word and carries it through the ID/EX, EX/MEM and MEM/WB registers of the 5-stage MIPS pipeline.
- Detects load-use hazards and resolves beq in EX, producing stall, flush and PC-select.
- Inserts bubbles and counts retired instructions.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch  in  1 each  decoded controls.
- id_aluop  in  2  {ALUOp1, ALUOp2}.
- id_rs, id_rt, id_rd  in  REG_W  instruction register fields.
- ex_zero  in  1  ALU zero flag from EX.
- ex_valid, ex_alusrc, ex_memread, ex_memwrite, ex_branch  out  1  EX-stage controls.
- ex_aluop  out  2  EX-stage ALU op.
- ex_dest  out  REG_W  selected destination register.
- mem_valid, mem_memread, mem_memwrite  out  1  MEM-stage controls.
- wb_valid, wb_regwrite, wb_memtoreg  out  1  WB-stage controls.
- wb_dest  out  REG_W  write-back register index.
- stall  out  1  hold PC and IF/ID this cycle.
- flush_if  out  1  squash IF/ID contents this cycle.
- pc_src  out  1  select branch target.
- retired  out  CNT_W  count of instructions leaving WB.

Behaviour:
- Reset (sync, rst=1 at posedge): every registered output is 0. This covers all valid bits, all controls, dests and retired. With all valids at 0, stall, flush_if and pc_src evaluate to 0.
- Reset mid-operation discards all in-flight stages in one cycle.
- ID/EX register also holds ex_rt and ex_regwrite internally.
- Destination select in ID: dest = id_regdst ? id_rd : id_rt.
- Effective regwrite = id_regwrite & ~id_memwrite & (dest != 0). Stores and writes to $0 never reach WB as writes.
- Branch (EX, combinational):
  - pc_src = ex_valid & ex_branch & ex_zero.
  - flush_if = pc_src.
- Load-use hazard (combinational): stall = id_valid & ex_valid & ex_memread & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt) & ~pc_src.
- ID/EX update each posedge:
  - if pc_src or stall: load a bubble (valid=0, all controls 0, dest 0);
  - else: load the ID word with valid=id_valid. An invalid ID word still loads with all controls forced 0.
- Priority: pc_src over stall. A taken branch kills the stalled ID instruction and stall stays deasserted.
- EX/MEM and MEM/WB always advance (no back-pressure from MEM).
- Latency: an ID word appears at the ex_* outputs 1 cycle later, at mem_* after 2 cycles, and at wb_* after 3 cycles.
- Bubbles propagate with all controls 0.
- retired increments by 1 on each posedge where wb_valid=1. It wraps modulo 2^CNT_W with no saturation.
- ex_zero is ignored when ex_valid=0 or ex_branch=0.

Decomposition:
- Shared package ctrl_pkg holds:
  - ctrl_t struct with fields regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0];
  - opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100;
  - ALUOp constants ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10;
  - CTRL_BUBBLE constant (all zero).
- One sub-module, hazard_unit: purely combinational, computes stall from the ID and EX fields.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, id_valid=0 → all outputs 0, retired=0. After 10 idle cycles retired is still 0.
- R-type flow: ID add with rd=3, rt=2, regdst=1, regwrite=1, aluop=10 → next cycle ex_dest=3, ex_aluop=10. Three cycles after ID: wb_regwrite=1, wb_dest=3, wb_valid=1. retired increments to 1 one cycle later.
- Store gating: ID sw with regwrite=1, memwrite=1, rt=5 → mem_memwrite=1 two cycles after ID. wb_regwrite=0 with wb_valid=1.
- Load-use: lw with rt=4 in EX, ID add with rs=4 → stall=1 for exactly 1 cycle. Next ex_valid=0 (bubble), then the add enters EX.
- Load-use to $0: lw with rt=0 in EX, ID rs=0 → stall=0.
- Branch taken with simultaneous hazard: beq in EX with ex_zero=1 while the ID instruction would stall → pc_src=1, flush_if=1, stall=0. Next ex_valid=0. With ex_zero=0 instead → pc_src=0 and the ID instruction proceeds.
- Counter wrap (CNT_W=4): 16 valid instructions retired → retired returns to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-word types and MIPS decode constants for the pipeline control stager.
package ctrl_pkg;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Reference main-decoder table; unknown opcodes decode to a bubble.
  function automatic ctrl_t ctrl_decode(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (op)
      OP_RTYPE: begin c.regdst = 1'b1; c.regwrite = 1'b1; c.aluop = ALUOP_FUNCT; end
      OP_LW:    begin c.alusrc = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1;
                      c.memread = 1'b1; c.aluop = ALUOP_ADD; end
      OP_SW:    begin c.alusrc = 1'b1; c.memwrite = 1'b1; c.aluop = ALUOP_ADD; end
      OP_BEQ:   begin c.branch = 1'b1; c.aluop = ALUOP_SUB; end
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stager_hazard_unit.sv
// Load-use hazard detect: holds ID when the load in EX feeds an ID source register.
module hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_ex_valid,
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic             i_pc_src,
  output logic             o_stall
);

  logic w_src_match;

  assign w_src_match = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);
  // A taken branch squashes the ID instruction, so there is nothing to hold.
  assign o_stall = i_id_valid & i_ex_valid & i_ex_memread & (i_ex_rt != '0)
                 & w_src_match & ~i_pc_src;

endmodule

// File: rtl/ctrl_pipe_stager.sv
// Carries decoded ID controls through ID/EX, EX/MEM, MEM/WB with hazard, branch and retire logic.
module ctrl_pipe_stager
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_regdst,
  input  logic             id_alusrc,
  input  logic             id_memtoreg,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_branch,
  input  logic [1:0]       id_aluop,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_zero,
  output logic             ex_valid,
  output logic             ex_alusrc,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_branch,
  output logic [1:0]       ex_aluop,
  output logic [REG_W-1:0] ex_dest,
  output logic             mem_valid,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             wb_valid,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [REG_W-1:0] wb_dest,
  output logic             stall,
  output logic             flush_if,
  output logic             pc_src,
  output logic [CNT_W-1:0] retired
);

  ctrl_t            w_id_ctrl;
  logic [REG_W-1:0] w_id_dest;
  logic             w_id_regwrite;
  logic             w_pc_src;
  logic             w_stall;
  logic             w_ex_load;

  logic             r_ex_valid, r_ex_alusrc, r_ex_memtoreg, r_ex_regwrite;
  logic             r_ex_memread, r_ex_memwrite, r_ex_branch;
  logic [1:0]       r_ex_aluop;
  logic [REG_W-1:0] r_ex_dest, r_ex_rt;

  logic             r_mem_valid, r_mem_memread, r_mem_memwrite, r_mem_regwrite, r_mem_memtoreg;
  logic [REG_W-1:0] r_mem_dest;

  logic             r_wb_valid, r_wb_regwrite, r_wb_memtoreg;
  logic [REG_W-1:0] r_wb_dest;
  logic [CNT_W-1:0] r_retired;

  // An invalid ID slot carries no controls, so it behaves like a bubble downstream.
  assign w_id_ctrl = id_valid ? ctrl_t'{id_regdst, id_alusrc, id_memtoreg, id_regwrite,
                                        id_memread, id_memwrite, id_branch, id_aluop}
                              : CTRL_BUBBLE;
  assign w_id_dest     = w_id_ctrl.regdst ? id_rd : id_rt;
  assign w_id_regwrite = w_id_ctrl.regwrite & ~w_id_ctrl.memwrite & (w_id_dest != '0);

  assign w_pc_src  = r_ex_valid & r_ex_branch & ex_zero;
  assign w_ex_load = id_valid & ~w_pc_src & ~w_stall;

  hazard_unit #(.REG_W(REG_W)) u_hazard (
    .i_id_valid   (id_valid),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_ex_valid   (r_ex_valid),
    .i_ex_memread (r_ex_memread),
    .i_ex_rt      (r_ex_rt),
    .i_pc_src     (w_pc_src),
    .o_stall      (w_stall)
  );

  always_ff @(posedge clk) begin
    if (rst || !w_ex_load) begin
      r_ex_valid    <= 1'b0;
      r_ex_alusrc   <= 1'b0;
      r_ex_memtoreg <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_branch   <= 1'b0;
      r_ex_aluop    <= '0;
      r_ex_dest     <= '0;
      r_ex_rt       <= '0;
    end else begin
      r_ex_valid    <= 1'b1;
      r_ex_alusrc   <= w_id_ctrl.alusrc;
      r_ex_memtoreg <= w_id_ctrl.memtoreg;
      r_ex_regwrite <= w_id_regwrite;
      r_ex_memread  <= w_id_ctrl.memread;
      r_ex_memwrite <= w_id_ctrl.memwrite;
      r_ex_branch   <= w_id_ctrl.branch;
      r_ex_aluop    <= w_id_ctrl.aluop;
      r_ex_dest     <= w_id_dest;
      r_ex_rt       <= id_rt;
    end
  end

  // EX/MEM and MEM/WB never stall; bubbles flow through as all-zero words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_valid    <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_mem_memwrite <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_mem_dest     <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_dest      <= '0;
      r_retired      <= '0;
    end else begin
      r_mem_valid    <= r_ex_valid;
      r_mem_memread  <= r_ex_memread;
      r_mem_memwrite <= r_ex_memwrite;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memtoreg <= r_ex_memtoreg;
      r_mem_dest     <= r_ex_dest;
      r_wb_valid     <= r_mem_valid;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_memtoreg  <= r_mem_memtoreg;
      r_wb_dest      <= r_mem_dest;
      if (r_wb_valid) r_retired <= r_retired + 1'b1;
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_alusrc    = r_ex_alusrc;
  assign ex_memread   = r_ex_memread;
  assign ex_memwrite  = r_ex_memwrite;
  assign ex_branch    = r_ex_branch;
  assign ex_aluop     = r_ex_aluop;
  assign ex_dest      = r_ex_dest;
  assign mem_valid    = r_mem_valid;
  assign mem_memread  = r_mem_memread;
  assign mem_memwrite = r_mem_memwrite;
  assign wb_valid     = r_wb_valid;
  assign wb_regwrite  = r_wb_regwrite;
  assign wb_memtoreg  = r_wb_memtoreg;
  assign wb_dest      = r_wb_dest;
  assign stall        = w_stall;
  assign flush_if     = w_pc_src;
  assign pc_src       = w_pc_src;
  assign retired      = r_retired;

endmodule

// File: tb/tb_ctrl_pipe_stager.sv
// Bench for ctrl_pipe_stager: directed vector table, counter wrap, random run against a stage-slot model.
module tb_ctrl_pipe_stager;
  import ctrl_pkg::*;

  localparam int RW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch;
  logic [1:0] id_aluop;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic ex_zero;
  logic ex_valid, ex_alusrc, ex_memread, ex_memwrite, ex_branch;
  logic [1:0] ex_aluop;
  logic [RW-1:0] ex_dest;
  logic mem_valid, mem_memread, mem_memwrite;
  logic wb_valid, wb_regwrite, wb_memtoreg;
  logic [RW-1:0] wb_dest;
  logic stall, flush_if, pc_src;
  logic [CW-1:0] retired;

  ctrl_pipe_stager #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_regdst(id_regdst), .id_alusrc(id_alusrc),
    .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_branch(id_branch), .id_aluop(id_aluop), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero), .ex_valid(ex_valid), .ex_alusrc(ex_alusrc),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_aluop(ex_aluop), .ex_dest(ex_dest), .mem_valid(mem_valid), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .wb_dest(wb_dest), .stall(stall), .flush_if(flush_if),
    .pc_src(pc_src), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; ctrl_t c; logic [RW-1:0] rs, rt, rd; logic z;
  } in_t;

  typedef struct {
    in_t i;
    logic stall, pc;
    logic exv; logic [RW-1:0] exd; logic mmw;
    logic wbv, wbrw; logic [RW-1:0] wbd; int ret;
  } vec_t;

  // Instruction as seen in one pipeline slot; an empty slot is all zero.
  typedef struct {
    bit v, alusrc, memread, memwrite, branch, memtoreg, rw;
    bit [1:0] aluop; bit [RW-1:0] dest, rt;
  } slot_t;

  int total = 0;
  int bad = 0;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input logic v, input ctrl_t c, input int rs, input int rt,
                             input int rd, input logic z);
    in_t x;
    x.v = v; x.c = c; x.rs = RW'(rs); x.rt = RW'(rt); x.rd = RW'(rd); x.z = z;
    return x;
  endfunction

  task automatic setrow(input int k, input in_t x, input logic s, input logic p, input logic exv,
                        input int exd, input logic mmw, input logic wbv, input logic wbrw,
                        input int wbd, input int ret);
    tbl[k].i = x; tbl[k].stall = s; tbl[k].pc = p; tbl[k].exv = exv; tbl[k].exd = RW'(exd);
    tbl[k].mmw = mmw; tbl[k].wbv = wbv; tbl[k].wbrw = wbrw; tbl[k].wbd = RW'(wbd);
    tbl[k].ret = ret;
  endtask

  task automatic apply(input in_t x);
    id_valid = x.v; id_regdst = x.c.regdst; id_alusrc = x.c.alusrc; id_memtoreg = x.c.memtoreg;
    id_regwrite = x.c.regwrite; id_memread = x.c.memread; id_memwrite = x.c.memwrite;
    id_branch = x.c.branch; id_aluop = x.c.aluop; id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
    ex_zero = x.z;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ex_valid, ex_alusrc, ex_memread, ex_memwrite, ex_branch, ex_aluop, ex_dest,
                mem_valid, mem_memread, mem_memwrite, wb_valid, wb_regwrite, wb_memtoreg,
                wb_dest, stall, flush_if, pc_src, retired});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    apply(mk(1'b0, CTRL_BUBBLE, 0, 0, 0, 1'b0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    ctrl_t c_r, c_lw, c_sw, c_beq, c_wd;
    slot_t s_ex, s_mem, s_wb, s_new;
    in_t x;
    int cnt;
    logic e_pc, e_stall;

    c_r = ctrl_decode(OP_RTYPE);
    c_lw = ctrl_decode(OP_LW);
    c_sw = ctrl_decode(OP_SW);  c_sw.regwrite = 1'b1;
    c_beq = ctrl_decode(OP_BEQ);
    c_wd = c_beq;               c_wd.memread = 1'b1;

    //      k  input                           st pc exv exd mmw wbv wbrw wbd ret
    setrow( 0, mk(1, c_r,   1,  2,  3, 0),      0, 0, 1,  3,  0,  0,  0,   0,  0);
    setrow( 1, mk(1, c_sw,  1,  5,  0, 0),      0, 0, 1,  5,  0,  0,  0,   0,  0);
    setrow( 2, mk(0, c_r,   1,  2,  9, 0),      0, 0, 0,  0,  1,  1,  1,   3,  0);
    setrow( 3, mk(1, c_lw,  1,  4,  0, 0),      0, 0, 1,  4,  0,  1,  0,   5,  1);
    setrow( 4, mk(1, c_r,   4,  6,  7, 0),      1, 0, 0,  0,  0,  0,  0,   0,  2);
    setrow( 5, mk(1, c_r,   4,  6,  7, 0),      0, 0, 1,  7,  0,  1,  1,   4,  2);
    setrow( 6, mk(1, c_beq, 7,  8,  0, 0),      0, 0, 1,  8,  0,  0,  0,   0,  3);
    setrow( 7, mk(1, c_lw,  2,  9,  0, 1),      0, 1, 0,  0,  0,  1,  1,   7,  3);
    setrow( 8, mk(1, c_lw,  2, 10,  0, 0),      0, 0, 1, 10,  0,  1,  0,   8,  4);
    setrow( 9, mk(1, c_wd, 10, 11,  0, 1),      1, 0, 0,  0,  0,  0,  0,   0,  5);
    setrow(10, mk(1, c_wd, 10, 11,  0, 1),      0, 0, 1, 11,  0,  1,  1,  10,  5);
    setrow(11, mk(1, c_r,  11,  1, 12, 1),      0, 1, 0,  0,  0,  0,  0,   0,  6);
    setrow(12, mk(0, c_lw,  1,  2,  0, 1),      0, 0, 0,  0,  0,  1,  0,  11,  6);
    setrow(13, mk(1, c_lw,  1,  0,  0, 0),      0, 0, 1,  0,  0,  0,  0,   0,  7);
    setrow(14, mk(1, c_r,   0,  0,  5, 0),      0, 0, 1,  5,  0,  0,  0,   0,  7);

    // Reset then idle
    do_reset();
    chk("reset_outputs", all_outs(), 64'd0);
    repeat (10) @(posedge clk);
    #1 chk("idle_retired", 64'(retired), 64'd0);
    chk("idle_outputs", all_outs(), 64'd0);

    // Directed vector table
    do_reset();
    for (int k = 0; k < 15; k++) begin
      apply(tbl[k].i);
      #1;
      chk($sformatf("v%0d_stall", k), 64'(stall), 64'(tbl[k].stall));
      chk($sformatf("v%0d_pc_src", k), 64'(pc_src), 64'(tbl[k].pc));
      chk($sformatf("v%0d_flush", k), 64'(flush_if), 64'(tbl[k].pc));
      @(posedge clk); #1;
      chk($sformatf("v%0d_ex_valid", k), 64'(ex_valid), 64'(tbl[k].exv));
      chk($sformatf("v%0d_ex_dest", k), 64'(ex_dest), 64'(tbl[k].exd));
      chk($sformatf("v%0d_mem_memwrite", k), 64'(mem_memwrite), 64'(tbl[k].mmw));
      chk($sformatf("v%0d_wb_valid", k), 64'(wb_valid), 64'(tbl[k].wbv));
      chk($sformatf("v%0d_wb_regwrite", k), 64'(wb_regwrite), 64'(tbl[k].wbrw));
      chk($sformatf("v%0d_wb_dest", k), 64'(wb_dest), 64'(tbl[k].wbd));
      chk($sformatf("v%0d_retired", k), 64'(retired), 64'(tbl[k].ret));
    end

    // Counter wrap: 15 retire to the top value, one more wraps to zero
    do_reset();
    apply(mk(1, c_r, 1, 2, 3, 0));
    repeat (15) @(posedge clk);
    #1 apply(mk(0, CTRL_BUBBLE, 0, 0, 0, 0));
    repeat (5) @(posedge clk);
    #1 chk("wrap_at_max", 64'(retired), 64'd15);
    apply(mk(1, c_r, 1, 2, 3, 0));
    @(posedge clk);
    #1 apply(mk(0, CTRL_BUBBLE, 0, 0, 0, 0));
    repeat (5) @(posedge clk);
    #1 chk("wrap_to_zero", 64'(retired), 64'd0);

    // Random run against slot model
    do_reset();
    s_ex = '{default: 0}; s_mem = '{default: 0}; s_wb = '{default: 0};
    cnt = 0;
    for (int n = 0; n < 400; n++) begin
      x.v = ($urandom_range(0, 3) != 0);
      x.c = ctrl_t'($urandom);
      x.rs = RW'($urandom_range(0, 3));
      x.rt = RW'($urandom_range(0, 3));
      x.rd = RW'($urandom_range(0, 3));
      x.z = 1'($urandom);
      apply(x);
      e_pc = s_ex.v && s_ex.branch && x.z;
      e_stall = x.v && s_ex.v && s_ex.memread && s_ex.rt != 0 &&
                (s_ex.rt == x.rs || s_ex.rt == x.rt) && !e_pc;
      #1;
      chk("rnd_stall", 64'(stall), 64'(e_stall));
      chk("rnd_pc_src", 64'(pc_src), 64'(e_pc));
      chk("rnd_flush", 64'(flush_if), 64'(e_pc));
      s_new = '{default: 0};
      if (x.v && !e_pc && !e_stall) begin
        s_new.v = 1; s_new.alusrc = x.c.alusrc; s_new.memread = x.c.memread;
        s_new.memwrite = x.c.memwrite; s_new.branch = x.c.branch;
        s_new.memtoreg = x.c.memtoreg; s_new.aluop = x.c.aluop;
        s_new.dest = x.c.regdst ? x.rd : x.rt; s_new.rt = x.rt;
        s_new.rw = x.c.regwrite && !x.c.memwrite && s_new.dest != 0;
      end
      if (s_wb.v) cnt = (cnt + 1) % (1 << CW);
      s_wb = s_mem; s_mem = s_ex; s_ex = s_new;
      @(posedge clk); #1;
      chk("rnd_ex", 64'({ex_valid, ex_alusrc, ex_memread, ex_memwrite, ex_branch, ex_aluop, ex_dest}),
          64'({s_ex.v, s_ex.alusrc, s_ex.memread, s_ex.memwrite, s_ex.branch, s_ex.aluop, s_ex.dest}));
      chk("rnd_mem", 64'({mem_valid, mem_memread, mem_memwrite}),
          64'({s_mem.v, s_mem.memread, s_mem.memwrite}));
      chk("rnd_wb", 64'({wb_valid, wb_regwrite, wb_memtoreg, wb_dest}),
          64'({s_wb.v, s_wb.rw, s_wb.memtoreg, s_wb.dest}));
      chk("rnd_retired", 64'(retired), 64'(cnt));
    end

    // Mid-operation reset flushes every stage in one edge
    apply(mk(1, c_r, 1, 2, 3, 0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    apply(mk(0, CTRL_BUBBLE, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midop_reset", all_outs(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
